// File: rtl/sm_input_sync.sv
// sm_input_sync: per-channel synchronizer, debounce filter and rise/fall strobes
// for asynchronous board inputs.
module sm_input_sync #(
   parameter int WIDTH = 5,
   parameter int STAGES = 2,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W = 3,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);
   if (STAGES < 2 || DEBOUNCE < 1 || (2 ** CNT_W) < DEBOUNCE) begin : g_bad_params
      $fatal(1, "sm_input_sync: need STAGES>=2, DEBOUNCE>=1, 2**CNT_W>=DEBOUNCE");
   end
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync [WIDTH];
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] s, hit;
   // hit: this clock accepts the synchronized level as the new output
   always_comb begin
      s = '0;
      hit = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = sync[i][STAGES-1];
         hit[i] = tick && (s[i] != dout[i]) && (cnt[i] == CNT_W'(DEBOUNCE - 1));
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            sync[i] <= {STAGES{RESET_VALUE[i]}};
            cnt[i] <= '0;
         end
         dout <= RESET_VALUE;
         rise <= '0;
         fall <= '0;
         changed <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sync[i] <= {sync[i][STAGES-2:0], din[i]};
            cnt[i] <= (s[i] == dout[i] || hit[i]) ? '0 : tick ? cnt[i] + CNT_W'(1) : cnt[i];
         end
         dout <= (dout & ~hit) | (s & hit);
         rise <= hit & s;
         fall <= hit & dout;
         changed <= |hit;
      end
   end
endmodule
